// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: decides when the IP/UDP sender transmits the next camera
// packet, drives packet index and UDP/IP length fields, and spaces packets.
// Optional feature: define UDP_TX_PARTIAL_FLUSH_EN to send the sub-payload
// remainder of a frame as a short final packet after frame end.
module udp_tx_scheduler #(
    parameter int unsigned PAYLOAD_BYTES = 1024,
    parameter int unsigned GAP_CYCLES    = 96,
    parameter int unsigned FIFO_FULL_LVL = 2047
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic [10:0] fifo_data_count,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic        tx_done,
    output logic [10:0] frame_index,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        busy,
    output logic        overflow_err
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PAYLOAD_LEN = CNT_W'(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] FULL_LVL    = CNT_W'(FIFO_FULL_LVL);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] UDP_HDR     = LEN_W'(8);
    localparam logic [LEN_W-1:0] IP_UDP_HDR  = LEN_W'(28);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_len;
    logic               w_end_clr;
    logic               w_restart;
    logic               w_req_entry;

    logic               r_end_pend;
    logic               r_start_pend;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_tx_req;
    logic [CNT_W-1:0]   r_frame_index;
    logic [LEN_W-1:0]   r_data_len;
    logic [LEN_W-1:0]   r_total_len;
    logic               r_busy;
    logic               r_overflow;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and packet length selection
    always_comb begin
        w_state_nx = r_state;
        w_len      = PAYLOAD_LEN;
        w_end_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nx = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (fifo_data_count >= PAYLOAD_LEN) begin
                    w_state_nx = S_REQ;
                    w_len      = PAYLOAD_LEN;
                end else if (r_end_pend) begin
`ifdef UDP_TX_PARTIAL_FLUSH_EN
                    if (fifo_data_count == '0) begin
                        w_state_nx = S_IDLE;
                        w_end_clr  = 1'b1;
                    end else begin
                        // frame-end flag stays set so the post-gap visit sees count 0
                        w_state_nx = S_REQ;
                        w_len      = fifo_data_count;
                    end
`else
                    // any sub-payload residue is left for the capture logic to flush
                    w_state_nx = S_IDLE;
                    w_end_clr  = 1'b1;
`endif
                end
            end
            S_REQ: begin
                if (tx_ack) begin
                    w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_done) begin
                    w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nx = S_WAIT_DATA;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_restart   = (r_state == S_GAP) && (w_state_nx == S_WAIT_DATA) && r_start_pend;
    assign w_req_entry = (r_state != S_REQ) && (w_state_nx == S_REQ);

    // Frame start/end event latching; end is applied before a coincident start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_end_pend   <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            if ((r_state == S_IDLE && frame_start) || w_restart || w_end_clr) begin
                r_end_pend <= 1'b0;
            end else if (frame_end) begin
                r_end_pend <= 1'b1;
            end
            if (frame_start && r_state != S_IDLE) begin
                r_start_pend <= 1'b1;
            end else if (w_restart) begin
                r_start_pend <= 1'b0;
            end
        end
    end

    // Inter-packet gap counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP && w_state_nx == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Registered outputs: request, busy, index, length fields, overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_req      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_index <= '0;
            r_data_len    <= '0;
            r_total_len   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_tx_req <= (w_state_nx == S_REQ);
            r_busy   <= (w_state_nx != S_IDLE) && (w_state_nx != S_WAIT_DATA);
            if (fifo_data_count >= FULL_LVL) begin
                r_overflow <= 1'b1;
            end
            if (w_req_entry) begin
                r_data_len  <= LEN_W'(w_len) + UDP_HDR;
                r_total_len <= LEN_W'(w_len) + IP_UDP_HDR;
            end
            if ((r_state == S_IDLE && frame_start) || w_restart) begin
                r_frame_index <= '0;
            end else if (r_state == S_SEND && tx_done) begin
                r_frame_index <= r_frame_index + CNT_W'(1);
            end
        end
    end

    assign tx_req          = r_tx_req;
    assign busy            = r_busy;
    assign frame_index     = r_frame_index;
    assign tx_data_length  = r_data_len;
    assign tx_total_length = r_total_len;
    assign overflow_err    = r_overflow;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: the stimulus pushes the expected
// index/length fields of each packet; a monitor pops them on every tx_req rise.
module tb_udp_tx_scheduler;

    localparam int unsigned TB_GAP = 6;

    typedef struct packed {
        logic [10:0] idx;
        logic [15:0] dlen;
        logic [15:0] tlen;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        frame_end;
    logic [10:0] fifo_data_count;
    logic        tx_req;
    logic        tx_ack;
    logic        tx_done;
    logic [10:0] frame_index;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        busy;
    logic        overflow_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cyc = 0;
    int   req_at   = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_req = 1'b0;

    udp_tx_scheduler #(
        .PAYLOAD_BYTES(1024),
        .GAP_CYCLES   (TB_GAP),
        .FIFO_FULL_LVL(2047)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .fifo_data_count(fifo_data_count),
        .tx_req         (tx_req),
        .tx_ack         (tx_ack),
        .tx_done        (tx_done),
        .frame_index    (frame_index),
        .tx_data_length (tx_data_length),
        .tx_total_length(tx_total_length),
        .busy           (busy),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] idx, input logic [15:0] dlen, input logic [15:0] tlen);
        exp_t e;
        e.idx  = idx;
        e.dlen = dlen;
        e.tlen = tlen;
        sb.push_back(e);
    endtask

    // Bounded wait for tx_req; records the cycle it was seen
    task automatic wait_req();
        int i;
        for (i = 0; i < 300; i++) begin
            if (tx_req) break;
            tick(1);
        end
        req_at = cyc;
        if (!tx_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: tx_req not seen within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    // Sender model: ack now, stay in SEND for 'hold' cycles, then done
    task automatic serve(input int hold);
        tx_ack = 1'b1;
        tick(1);
        tx_ack = 1'b0;
        tick(hold);
        tx_done  = 1'b1;
        done_cyc = cyc;
        tick(1);
        tx_done = 1'b0;
    endtask

    // Monitor: every new request must match the oldest expected packet
    always @(negedge clk) begin
        if (reset) begin
            prev_req <= 1'b0;
        end else begin
            if (tx_req && !prev_req) begin
                check("sb_has_expected_req", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("req_frame_index", 32'(frame_index), 32'(mon_e.idx));
                    check("req_data_length", 32'(tx_data_length), 32'(mon_e.dlen));
                    check("req_total_length", 32'(tx_total_length), 32'(mon_e.tlen));
                end
            end
            prev_req <= tx_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        frame_start     = 1'b0;
        frame_end       = 1'b0;
        fifo_data_count = '0;
        tx_ack          = 1'b0;
        tx_done         = 1'b0;
        tick(3);
        check("rst_tx_req", 32'(tx_req), 0);
        check("rst_frame_index", 32'(frame_index), 0);
        check("rst_data_length", 32'(tx_data_length), 0);
        check("rst_total_length", 32'(tx_total_length), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow_err), 0);
        reset = 1'b0;
        tick(1);

        // Full packet: threshold reached -> request on the next cycle
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("wait_busy", 32'(busy), 0);
        push(11'd0, 16'd1032, 16'd1052);
        fifo_data_count = 11'd1024;
        tick(1);
        check("req_latency", 32'(tx_req), 1);
        check("req_busy", 32'(busy), 1);
        tx_ack = 1'b1;
        tick(1);
        tx_ack = 1'b0;
        check("req_drop_after_ack", 32'(tx_req), 0);
        tick(3);
        tx_done  = 1'b1;
        done_cyc = cyc;
        tick(1);
        tx_done = 1'b0;
        check("index_after_done", 32'(frame_index), 1);
        push(11'd1, 16'd1032, 16'd1052);
        wait_req();
        check("packet_spacing", 32'(req_at - done_cyc), 32'(TB_GAP + 2));

        // Below threshold: 1023 never requests; stray ack/done are ignored
        fifo_data_count = 11'd1023;
        serve(2);
        tick(20);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("done_outside_send", 32'(frame_index), 2);
        tx_ack = 1'b1;
        tick(1);
        tx_ack = 1'b0;
        tick(30);
        check("below_threshold_no_req", 32'(tx_req), 0);
        push(11'd2, 16'd1032, 16'd1052);
        fifo_data_count = 11'd1024;
        tick(1);
        check("threshold_cross_req", 32'(tx_req), 1);
        serve(2);

        // Packets 3 and 4, then frame_start during SEND of packet 5
        push(11'd3, 16'd1032, 16'd1052);
        wait_req();
        serve(2);
        push(11'd4, 16'd1032, 16'd1052);
        wait_req();
        serve(2);
        push(11'd5, 16'd1032, 16'd1052);
        wait_req();
        tx_ack = 1'b1;
        tick(1);
        tx_ack      = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("index_incr_before_restart", 32'(frame_index), 6);
        push(11'd0, 16'd1032, 16'd1052);
        wait_req();
        fifo_data_count = 11'd300;
        serve(2);
        tick(TB_GAP + 6);

        // Frame end with a 300-byte remainder
`ifdef UDP_TX_PARTIAL_FLUSH_EN
        push(11'd1, 16'd308, 16'd328);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        wait_req();
        fifo_data_count = 11'd0;
        serve(2);
        tick(TB_GAP + 6);
`else
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        tick(5);
`endif
        check("flush_idle_busy", 32'(busy), 0);
        fifo_data_count = 11'd1024;
        tick(10);
        check("idle_ignores_count", 32'(tx_req), 0);

        // 2048 packets: index wraps back to 0
        push(11'd0, 16'd1032, 16'd1052);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            wait_req();
            serve(2);
            push(11'(i + 1), 16'd1032, 16'd1052);
        end
        check("index_wrap", 32'(frame_index), 0);
        wait_req();
        serve(2);
        push(11'd1, 16'd1032, 16'd1052);
        wait_req();
        tx_ack = 1'b1;
        tick(1);
        tx_ack = 1'b0;
        check("send_busy", 32'(busy), 1);

        // Sticky overflow
        fifo_data_count = 11'd2047;
        tick(1);
        check("overflow_set", 32'(overflow_err), 1);
        fifo_data_count = 11'd1024;
        tick(3);
        check("overflow_sticky", 32'(overflow_err), 1);

        // Reset during SEND
        reset = 1'b1;
        tick(1);
        check("send_rst_tx_req", 32'(tx_req), 0);
        check("send_rst_frame_index", 32'(frame_index), 0);
        check("send_rst_data_length", 32'(tx_data_length), 0);
        check("send_rst_total_length", 32'(tx_total_length), 0);
        check("send_rst_busy", 32'(busy), 0);
        check("send_rst_overflow", 32'(overflow_err), 0);
        reset = 1'b0;
        tick(10);
        check("post_reset_idle", 32'(tx_req), 0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
